// File: rtl/adc_capture_if.sv
// Bundle of the control, sample-stream and RAM-write signals around the
// ADC capture sequencer. The master side configures the block and feeds
// samples; the slave side is the sequencer itself.
interface adc_capture_if #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DECIM_W = 8
);
    logic               start;
    logic               abort;
    logic               trig_mode;
    logic [DATA_W-1:0]  trig_level;
    logic [DECIM_W-1:0] decim;
    logic [ADDR_W:0]    sample_len;
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               busy;
    logic               done;
    logic [ADDR_W:0]    sample_cnt;
    logic [1:0]         state;

    modport master (
        output start, abort, trig_mode, trig_level, decim, sample_len, in_data, in_valid,
        input  wr_en, wr_addr, wr_data, busy, done, sample_cnt, state
    );

    modport slave (
        input  start, abort, trig_mode, trig_level, decim, sample_len, in_data, in_valid,
        output wr_en, wr_addr, wr_data, busy, done, sample_cnt, state
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer: arms on start, waits for an immediate or rising
// threshold trigger, then decimates and writes a fixed-length record into
// the sample RAM, pulsing done together with the final write.
module adc_capture_ctrl #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DECIM_W = 8
) (
    input logic          adc_clk,
    input logic          rst,
    adc_capture_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_e             state_q, state_d;
    logic               cfg_mode_q, cfg_mode_d;
    logic [DATA_W-1:0]  cfg_level_q, cfg_level_d;
    logic [DECIM_W-1:0] cfg_decim_q, cfg_decim_d;
    logic [ADDR_W:0]    cfg_len_q, cfg_len_d;
    logic [DECIM_W-1:0] dec_cnt_q, dec_cnt_d;
    logic               prev_valid_q, prev_valid_d;
    logic [DATA_W-1:0]  prev_sample_q, prev_sample_d;
    logic [ADDR_W:0]    sample_cnt_q, sample_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               done_q, done_d;

    logic [ADDR_W:0]    len_clamped;
    logic [DECIM_W-1:0] eff_decim;
    logic [ADDR_W:0]    cnt_inc;
    logic               dec_last;
    logic               thresh_hit;
    logic               keep;

    // Derived helpers: clamped length, effective decimation, trigger test
    always_comb begin
        len_clamped = (bus.sample_len > MAX_LEN) ? MAX_LEN : bus.sample_len;
        eff_decim   = (cfg_decim_q == '0) ? DECIM_W'(1) : cfg_decim_q;
        cnt_inc     = sample_cnt_q + 1'b1;
        dec_last    = (dec_cnt_q == (eff_decim - 1'b1));
        // Rising crossing needs a previous sample strictly below the level
        thresh_hit  = prev_valid_q && (prev_sample_q < cfg_level_q) &&
                      (bus.in_data >= cfg_level_q);
    end

    // Next-state and registered-output logic; abort overrides everything
    always_comb begin
        state_d       = state_q;
        cfg_mode_d    = cfg_mode_q;
        cfg_level_d   = cfg_level_q;
        cfg_decim_d   = cfg_decim_q;
        cfg_len_d     = cfg_len_q;
        dec_cnt_d     = dec_cnt_q;
        prev_valid_d  = prev_valid_q;
        prev_sample_d = prev_sample_q;
        sample_cnt_d  = sample_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        done_d        = 1'b0;
        keep          = 1'b0;

        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        cfg_mode_d   = bus.trig_mode;
                        cfg_level_d  = bus.trig_level;
                        cfg_decim_d  = bus.decim;
                        cfg_len_d    = len_clamped;
                        sample_cnt_d = '0;
                        wr_addr_d    = '0;
                        dec_cnt_d    = '0;
                        prev_valid_d = 1'b0;
                        if (len_clamped == '0) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (bus.in_valid) begin
                        prev_sample_d = bus.in_data;
                        prev_valid_d  = 1'b1;
                        if (!cfg_mode_q || thresh_hit) begin
                            // Trigger sample is kept; decimation phase restarts here
                            keep      = 1'b1;
                            dec_cnt_d = '0;
                            state_d   = StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (bus.in_valid) begin
                        if (dec_last) begin
                            dec_cnt_d = '0;
                            keep      = 1'b1;
                        end else begin
                            dec_cnt_d = dec_cnt_q + 1'b1;
                        end
                    end
                end
            endcase

            if (keep) begin
                wr_en_d      = 1'b1;
                wr_data_d    = bus.in_data;
                wr_addr_d    = sample_cnt_q[ADDR_W-1:0];
                sample_cnt_d = cnt_inc;
                if (cnt_inc == cfg_len_q) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cfg_mode_q    <= 1'b0;
            cfg_level_q   <= '0;
            cfg_decim_q   <= '0;
            cfg_len_q     <= '0;
            dec_cnt_q     <= '0;
            prev_valid_q  <= 1'b0;
            prev_sample_q <= '0;
            sample_cnt_q  <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_mode_q    <= cfg_mode_d;
            cfg_level_q   <= cfg_level_d;
            cfg_decim_q   <= cfg_decim_d;
            cfg_len_q     <= cfg_len_d;
            dec_cnt_q     <= dec_cnt_d;
            prev_valid_q  <= prev_valid_d;
            prev_sample_q <= prev_sample_d;
            sample_cnt_q  <= sample_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.done       = done_q;
    assign bus.sample_cnt = sample_cnt_q;
    assign bus.state      = state_q;
    assign bus.busy       = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: table of directed records,
// hand-written corner sequences and a randomized run against a reference
// model that derives expected writes from the sample stream directly.
module tb_adc_capture_ctrl;

    localparam int DW  = 12;
    localparam int AW  = 10;
    localparam int DCW = 8;

    logic adc_clk = 1'b0;
    logic rst     = 1'b1;

    always #5 adc_clk = ~adc_clk;

    adc_capture_if #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(DCW)) bus ();

    adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(DCW)) dut (
        .adc_clk (adc_clk),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } wr_t;

    typedef struct packed {
        logic               mode;
        logic [DW-1:0]      level;
        logic [DCW-1:0]     decim;
        logic [AW:0]        len;
        logic [3:0]         nsamp;
        logic [0:9][DW-1:0] samp;
        logic [2:0]         nexp;
        logic [0:3][DW-1:0] expw;
    } vec_t;

    wr_t wq[$];
    int  done_cnt;
    int  checks;
    int  passed;

    // Write/done monitor, sampled mid-cycle
    always @(negedge adc_clk) begin
        if (!rst) begin
            if (bus.wr_en) wq.push_back('{addr: bus.wr_addr, data: bus.wr_data, done: bus.done});
            if (bus.done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive inputs for one clock edge; returns 1 time unit after the edge
    task automatic step(input logic st, input logic ab, input logic v, input logic [DW-1:0] d);
        bus.start    = st;
        bus.abort    = ab;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge adc_clk);
        #1;
    endtask

    // Arm with a config, then scramble the config inputs to prove they were latched
    task automatic arm(input logic m, input logic [DW-1:0] lv, input logic [DCW-1:0] dc,
                       input logic [AW:0] ln);
        bus.trig_mode  = m;
        bus.trig_level = lv;
        bus.decim      = dc;
        bus.sample_len = ln;
        step(1'b1, 1'b0, 1'b0, '0);
        bus.trig_mode  = 1'($urandom);
        bus.trig_level = 12'($urandom);
        bus.decim      = 8'($urandom);
        bus.sample_len = 11'($urandom);
    endtask

    task automatic clear_mon();
        wq.delete();
        done_cnt = 0;
    endtask

    vec_t vecs[6];

    initial begin
        checks = 0;
        passed = 0;
        done_cnt = 0;
        bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in_data = '0;
        bus.trig_mode = 0; bus.trig_level = '0; bus.decim = 8'd1; bus.sample_len = '0;

        vecs[0] = '{mode: 1'b0, level: 12'h000, decim: 8'd1, len: 11'd4, nsamp: 4'd5,
                    samp: {12'h010, 12'h020, 12'h030, 12'h040, 12'h050, {5{12'h000}}},
                    nexp: 3'd4, expw: {12'h010, 12'h020, 12'h030, 12'h040}};
        vecs[1] = '{mode: 1'b1, level: 12'h800, decim: 8'd1, len: 11'd2, nsamp: 4'd5,
                    samp: {12'h900, 12'h100, 12'h7FF, 12'h800, 12'h900, {5{12'h000}}},
                    nexp: 3'd2, expw: {12'h800, 12'h900, {2{12'h000}}}};
        vecs[2] = '{mode: 1'b0, level: 12'h000, decim: 8'd3, len: 11'd3, nsamp: 4'd9,
                    samp: {12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8, 12'd9, 12'd0},
                    nexp: 3'd3, expw: {12'd1, 12'd4, 12'd7, 12'd0}};
        vecs[3] = '{mode: 1'b0, level: 12'h000, decim: 8'd0, len: 11'd3, nsamp: 4'd4,
                    samp: {12'h005, 12'h006, 12'h007, 12'h008, {6{12'h000}}},
                    nexp: 3'd3, expw: {12'h005, 12'h006, 12'h007, 12'h000}};
        vecs[4] = '{mode: 1'b0, level: 12'h000, decim: 8'd1, len: 11'd0, nsamp: 4'd2,
                    samp: {12'h0AA, 12'h0BB, {8{12'h000}}},
                    nexp: 3'd0, expw: {4{12'h000}}};
        vecs[5] = '{mode: 1'b1, level: 12'h250, decim: 8'd4, len: 11'd1, nsamp: 4'd3,
                    samp: {12'h100, 12'h300, 12'h200, {7{12'h000}}},
                    nexp: 3'd1, expw: {12'h300, {3{12'h000}}}};

        // Reset values
        step(0, 0, 0, '0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_cnt", 32'(bus.sample_cnt), 0);
        rst = 1'b0;
        step(0, 0, 1, 12'h123);
        chk("idle_valid_ignored", 32'(bus.wr_en), 0);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            arm(vecs[v].mode, vecs[v].level, vecs[v].decim, vecs[v].len);
            for (int i = 0; i < int'(vecs[v].nsamp); i++) step(0, 0, 1, vecs[v].samp[i]);
            step(0, 0, 0, '0);
            step(0, 0, 0, '0);
            chk($sformatf("v%0d_nwr", v), 32'(wq.size()), 32'(vecs[v].nexp));
            for (int i = 0; i < int'(vecs[v].nexp); i++) begin
                if (i < wq.size()) begin
                    chk($sformatf("v%0d_addr%0d", v, i), 32'(wq[i].addr), 32'(i));
                    chk($sformatf("v%0d_data%0d", v, i), 32'(wq[i].data), 32'(vecs[v].expw[i]));
                end
            end
            if (vecs[v].nexp != 0 && wq.size() != 0)
                chk($sformatf("v%0d_done_last", v), 32'(wq[wq.size()-1].done), 1);
            chk($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 1);
            chk($sformatf("v%0d_cnt", v), 32'(bus.sample_cnt), 32'(vecs[v].len));
            chk($sformatf("v%0d_state", v), 32'(bus.state), 3);
            chk($sformatf("v%0d_busy", v), 32'(bus.busy), 0);
        end

        // Empty record: done one cycle after start, then drops
        clear_mon();
        arm(0, '0, 8'd1, 11'd0);
        chk("len0_done", 32'(bus.done), 1);
        chk("len0_state", 32'(bus.state), 3);
        chk("len0_wr_en", 32'(bus.wr_en), 0);
        step(0, 0, 0, '0);
        chk("len0_done_drop", 32'(bus.done), 0);

        // Abort during capture after two writes
        clear_mon();
        arm(0, '0, 8'd1, 11'd8);
        chk("arm_busy", 32'(bus.busy), 1);
        chk("arm_state", 32'(bus.state), 1);
        step(0, 0, 1, 12'h0A1);
        step(0, 0, 1, 12'h0A2);
        chk("ab_state_cap", 32'(bus.state), 2);
        step(0, 1, 1, 12'h0A3);
        chk("ab_state", 32'(bus.state), 0);
        chk("ab_wr_en", 32'(bus.wr_en), 0);
        chk("ab_cnt", 32'(bus.sample_cnt), 2);
        step(0, 0, 1, 12'h0A4);
        chk("ab_nwr", 32'(wq.size()), 2);
        chk("ab_done", 32'(done_cnt), 0);

        // Start together with abort stays idle
        bus.sample_len = 11'd4;
        step(1, 1, 0, '0);
        chk("stab_state", 32'(bus.state), 0);
        chk("stab_busy", 32'(bus.busy), 0);

        // Start during capture is ignored
        clear_mon();
        arm(0, '0, 8'd1, 11'd3);
        step(0, 0, 1, 12'h111);
        bus.sample_len = 11'd1;
        step(1, 0, 1, 12'h222);
        step(0, 0, 1, 12'h333);
        step(0, 0, 0, '0);
        chk("sbusy_nwr", 32'(wq.size()), 3);
        if (wq.size() == 3) chk("sbusy_last", 32'(wq[2].data), 32'h333);
        chk("sbusy_done", 32'(done_cnt), 1);
        chk("sbusy_state", 32'(bus.state), 3);

        // Reset mid-capture, then a full fresh record
        arm(0, '0, 8'd1, 11'd4);
        step(0, 0, 1, 12'h051);
        step(0, 0, 1, 12'h052);
        rst = 1'b1;
        #2;
        chk("mrst_state", 32'(bus.state), 0);
        chk("mrst_wr_en", 32'(bus.wr_en), 0);
        chk("mrst_wr_addr", 32'(bus.wr_addr), 0);
        chk("mrst_wr_data", 32'(bus.wr_data), 0);
        chk("mrst_cnt", 32'(bus.sample_cnt), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        step(0, 0, 1, 12'h053);
        rst = 1'b0;
        clear_mon();
        arm(0, '0, 8'd1, 11'd3);
        step(0, 0, 1, 12'h007);
        step(0, 0, 1, 12'h008);
        step(0, 0, 1, 12'h009);
        step(0, 0, 0, '0);
        chk("mrst_nwr", 32'(wq.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wq.size()) begin
                chk($sformatf("mrst_addr%0d", i), 32'(wq[i].addr), 32'(i));
                chk($sformatf("mrst_data%0d", i), 32'(wq[i].data), 32'(7 + i));
            end
        end
        chk("mrst_done", 32'(done_cnt), 1);

        // Randomized records against the reference model
        for (int it = 0; it < 30; it++) begin
            logic           m;
            logic [DW-1:0]  lv;
            logic [DCW-1:0] dc;
            int             ln;
            int             d_eff;
            int             trig_idx;
            int             exp_state;
            logic [DW-1:0]  vs[$];
            logic [DW-1:0]  expq[$];
            bit             exp_done;

            m  = 1'($urandom_range(0, 1));
            lv = 12'($urandom_range(1000, 3000));
            dc = 8'($urandom_range(0, 4));
            ln = int'($urandom_range(0, 6));
            vs.delete();
            expq.delete();
            for (int i = 0; i < 30; i++) vs.push_back(12'($urandom_range(0, 4095)));

            d_eff = (dc == 0) ? 1 : int'(dc);
            trig_idx = -1;
            if (ln != 0) begin
                if (m == 1'b0) trig_idx = 0;
                else begin
                    for (int i = 1; i < vs.size(); i++) begin
                        if (vs[i-1] < lv && vs[i] >= lv) begin
                            trig_idx = i;
                            break;
                        end
                    end
                end
                if (trig_idx >= 0)
                    for (int i = trig_idx; i < vs.size() && expq.size() < ln; i += d_eff)
                        expq.push_back(vs[i]);
            end
            exp_done  = (expq.size() == ln);
            exp_state = exp_done ? 3 : ((trig_idx >= 0) ? 2 : 1);

            clear_mon();
            arm(m, lv, dc, 11'(ln));
            for (int i = 0; i < vs.size(); i++) begin
                while ($urandom_range(0, 2) == 0) step(0, 0, 0, 12'($urandom));
                step(0, 0, 1, vs[i]);
            end
            step(0, 0, 0, '0);
            step(0, 0, 0, '0);

            chk($sformatf("r%0d_nwr", it), 32'(wq.size()), 32'(expq.size()));
            for (int i = 0; i < expq.size(); i++) begin
                if (i < wq.size()) begin
                    chk($sformatf("r%0d_addr%0d", it, i), 32'(wq[i].addr), 32'(i));
                    chk($sformatf("r%0d_data%0d", it, i), 32'(wq[i].data), 32'(expq[i]));
                end
            end
            chk($sformatf("r%0d_done", it), 32'(done_cnt), exp_done ? 1 : 0);
            chk($sformatf("r%0d_cnt", it), 32'(bus.sample_cnt), 32'(expq.size()));
            chk($sformatf("r%0d_state", it), 32'(bus.state), 32'(exp_state));
            step(0, 1, 0, '0);
            chk($sformatf("r%0d_abort", it), 32'(bus.state), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Acquisition sequencer behind the ADC front-end. It consumes the captured-sample stream (`in_data`, `in_valid`), arms on a software start, and waits for an immediate or threshold trigger. It then decimates and writes a programmed number of samples into a single-port sample RAM, and signals completion. It sits between the ADC interface block and the capture buffer, in the same `adc_clk` domain.

## Interface
- `DATA_W`, 12, sample width.
- `ADDR_W`, 10, sample RAM address width. Max record length is 2^ADDR_W.
- `DECIM_W`, 8, decimation factor width.

- `adc_clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle arm request. Honoured only in IDLE or DONE.
- `abort`  in  1  one-cycle cancel. Honoured in any state.
- `trig_mode`  in  1  0 = immediate, 1 = rising threshold crossing.
- `trig_level`  in  DATA_W  threshold, unsigned.
- `decim`  in  DECIM_W  keep 1 of every `decim` samples. 0 is treated as 1.
- `sample_len`  in  ADDR_W+1  samples to store. 0 means empty record. Values above 2^ADDR_W are clamped to 2^ADDR_W.
- `in_data`  in  DATA_W  sample from the ADC interface.
- `in_valid`  in  1  one-cycle strobe qualifying `in_data`.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  DATA_W  RAM write data.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  one-cycle completion pulse.
- `sample_cnt`  out  ADDR_W+1  samples written in the current or last record.
- `state`  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

## Operation
- **Configuration latch:** `trig_mode`, `trig_level`, `decim` and `sample_len` are registered when `start` is accepted. Later changes have no effect until the next start.
- **IDLE / DONE + `start`:**
  - `sample_cnt` and `wr_addr` clear to 0.
  - Decimation counter clears to 0.
  - A "previous sample valid" flag clears.
  - Next state: DONE if the latched length is 0, with `done` pulsed. Otherwise ARMED.
- **ARMED, `trig_mode` = 0:** the first `in_valid` triggers.
- **ARMED, `trig_mode` = 1:** a trigger requires all of the following:
  - `in_valid`;
  - previous flag set;
  - `prev_sample < trig_level`;
  - `in_data >= trig_level`.
- **ARMED, other cycles:**
  - Every `in_valid` updates `prev_sample` and sets the previous flag.
  - The first valid sample after arming never triggers.
- **Trigger sample:** it is stored as address 0 regardless of `decim`. The decimation counter restarts so that this sample is counted as kept. State goes to CAPTURE.
- **CAPTURE decimation:** each `in_valid` advances a counter 0..D-1 (D = max(decim,1)). A sample is kept when the counter wraps to 0.
- **Kept sample write:**
  - `wr_en`=1, `wr_data`=sample, `wr_addr`=`sample_cnt`;
  - `sample_cnt` increments.
- **End of record:** the write that makes `sample_cnt` equal the latched length asserts `done` in the same cycle as that `wr_en`. State goes to DONE.
- **Address range:** `wr_addr` never wraps. Clamping of `sample_len` guarantees this.
- **DONE:** holds `sample_cnt`. No writes. Waits for `start`.
- **`abort`:**
  - State goes to IDLE next edge.
  - `wr_en` and `done` are suppressed that cycle.
  - `sample_cnt` holds its value.
  - `abort` takes priority over `start`, trigger and writes in the same cycle.
- **`start` while busy:** ignored, no restart.
- **`in_valid` in IDLE or DONE:** ignored.

## Timing
- **Reset values:** state=IDLE, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `sample_cnt`=0. Latched config is 0, decimation counter is 0, previous flag is 0.
- **Arming:** `start` at edge N → `state`/`busy` change visible after edge N.
- **Write latency:** all outputs are registered. An accepted `in_valid` at edge N produces `wr_en`/`wr_addr`/`wr_data` valid during cycle N+1, for exactly one cycle.
- **Trigger latency:** same 1 cycle. The trigger sample is written during the cycle after its `in_valid`.
- **`done`:** high for exactly one cycle. It coincides with the last `wr_en` and with `state` becoming DONE.
- **Back-to-back samples:** consecutive `in_valid` cycles are supported at full rate, with no stall.
- **Mid-operation reset:** any state returns immediately to reset values. No partial write is completed.

## Test plan
- **Immediate single sample, no decimation:** `trig_mode`=0, `decim`=1, `sample_len`=4; `start`, then `in_valid` with data 0x010,0x020,0x030,0x040,0x050 → writes addr 0..3 = 0x010..0x040. `done` accompanies the addr-3 write. `sample_cnt`=4. 0x050 is not written.
- **Threshold trigger:** `trig_mode`=1, `trig_level`=0x800, `sample_len`=2; samples 0x900, 0x100, 0x7FF, 0x800, 0x900 → no trigger on 0x900 (first sample) or 0x100. Trigger on 0x800. Writes addr0=0x800, addr1=0x900, then `done`.
- **Decimation:** `decim`=3, `sample_len`=3, immediate; samples 1..9 → writes 1, 4, 7; `done` with the write of 7.
- **`decim`=0 and `sample_len`=0:**
  - `decim`=0 behaves as 1.
  - `start` with `sample_len`=0 → `done` pulse one cycle after `start`, no `wr_en`, state DONE, `sample_cnt`=0.
- **Abort and collisions:**
  - `abort` during CAPTURE after 2 writes → IDLE, `sample_cnt`=2, no `done`.
  - `start`+`abort` together → IDLE.
  - `start` during CAPTURE → ignored, record continues.
- **Reset mid-capture:** assert `rst` during CAPTURE → all outputs at reset values asynchronously. A new `start` after release yields a full record from addr 0.
